// File: rtl/vram_scanout.sv
// Raster scan-out stage: timing counters, linear framebuffer read addressing,
// and a 3-clock aligned pixel/sync/blank output pipeline.
module vram_scanout #(
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 15,
  parameter int ADDR_W   = 17,
  parameter int PIXEL_W  = 8
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  fb_base,
  output logic [ADDR_W-1:0]  ram_addr,
  input  logic [PIXEL_W-1:0] ram_q,
  output logic [PIXEL_W-1:0] pixel,
  output logic               hsync,
  output logic               vsync,
  output logic               hblank,
  output logic               vblank,
  output logic               de,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic [ADDR_W-1:0] row_base;

  logic h_last, v_last;
  logic act0, hs0, vs0, hb0, vb0, fs0;

  logic act_d1, hs_d1, vs_d1, hb_d1, vb_d1, fs_d1;
  logic act_d2, hs_d2, vs_d2, hb_d2, vb_d2, fs_d2;

  always_comb begin
    h_last = (hcnt == HW'(H_TOTAL - 1));
    v_last = (vcnt == VW'(V_TOTAL - 1));
    hb0    = ~(hcnt < HW'(H_ACTIVE));
    vb0    = ~(vcnt < VW'(V_ACTIVE));
    act0   = ~hb0 & ~vb0;
    hs0    = (hcnt >= HW'(H_ACTIVE + H_FP)) && (hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs0    = (vcnt >= VW'(V_ACTIVE + V_FP)) && (vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    fs0    = (hcnt == '0) && (vcnt == '0);
  end

  // Raster counters and row base; fb_base is only taken at the frame wrap so
  // a mid-frame buffer flip never tears the picture.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hcnt     <= '0;
      vcnt     <= '0;
      row_base <= fb_base;
    end else if (h_last) begin
      hcnt <= '0;
      if (v_last) begin
        vcnt     <= '0;
        row_base <= fb_base;
      end else begin
        vcnt     <= vcnt + VW'(1);
        row_base <= row_base + ADDR_W'(H_ACTIVE);
      end
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // Stage 1: RAM address plus flag delay; the address holds during blanking.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ram_addr <= '0;
      act_d1   <= 1'b0;
      hs_d1    <= 1'b0;
      vs_d1    <= 1'b0;
      hb_d1    <= 1'b1;
      vb_d1    <= 1'b1;
      fs_d1    <= 1'b0;
    end else begin
      if (act0) ram_addr <= row_base + ADDR_W'(hcnt);
      act_d1 <= act0;
      hs_d1  <= hs0;
      vs_d1  <= vs0;
      hb_d1  <= hb0;
      vb_d1  <= vb0;
      fs_d1  <= fs0;
    end
  end

  // Stage 2 flags line up with ram_q; stage 3 registers everything to the pins.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      act_d2      <= 1'b0;
      hs_d2       <= 1'b0;
      vs_d2       <= 1'b0;
      hb_d2       <= 1'b1;
      vb_d2       <= 1'b1;
      fs_d2       <= 1'b0;
      pixel       <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      act_d2      <= act_d1;
      hs_d2       <= hs_d1;
      vs_d2       <= vs_d1;
      hb_d2       <= hb_d1;
      vb_d2       <= vb_d1;
      fs_d2       <= fs_d1;
      pixel       <= act_d2 ? ram_q : '0;
      hsync       <= hs_d2;
      vsync       <= vs_d2;
      hblank      <= hb_d2;
      vblank      <= vb_d2;
      de          <= act_d2;
      frame_start <= fs_d2;
    end
  end

endmodule
